// File: rtl/instr_encoder_loader_if.sv
// Field-bundle input handshake plus instruction-memory write port of the loader.
// master = bundle producer / memory side, slave = the encoder-loader itself.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_cond;
  logic [1:0]        in_op;
  logic [5:0]        in_funct;
  logic [3:0]        in_rn;
  logic [3:0]        in_rd;
  logic [11:0]       in_src2;
  logic [23:0]       in_imm24;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_cond, in_op, in_funct, in_rn, in_rd, in_src2, in_imm24,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_cond, in_op, in_funct, in_rn, in_rd, in_src2, in_imm24,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 32-bit machine words and writes them to
// consecutive instruction-memory addresses; unsupported encodings become a NOP.
module instr_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   num_instr_i,
  instr_encoder_loader_if.slave bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [7:0]        err_count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  // AND R0,R0,R0 with cond=always: architecturally a no-op.
  localparam logic [31:0]       NOP_WORD  = 32'hE000_0000;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_ONE   = 1;
  localparam logic [ADDR_W:0]   CNT_ZERO  = '0;
  localparam logic [7:0]        ERR_MAX   = 8'hFF;
  localparam logic [7:0]        ERR_ONE   = 8'h01;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [7:0]        err_count_q;

  logic              cmd_legal_d;
  logic              legal_d;
  logic [31:0]       enc_word_d;
  logic [31:0]       word_d;
  logic              accept_d;

  always_comb begin
    cmd_legal_d = 1'b0;
    case (bus.in_funct[4:1])
      4'b0100, 4'b0010, 4'b0000, 4'b1100,
      4'b1101, 4'b0001, 4'b1111: cmd_legal_d = 1'b1;
      default:                   cmd_legal_d = 1'b0;
    endcase

    legal_d = 1'b0;
    case (bus.in_op)
      2'b00:   legal_d = cmd_legal_d;
      2'b01:   legal_d = 1'b1;
      2'b10:   legal_d = bus.in_funct[5];
      default: legal_d = 1'b0;
    endcase

    // Branches carry only the link/sub-op bits of funct ahead of the 24-bit offset.
    if (bus.in_op == 2'b10) begin
      enc_word_d = {bus.in_cond, 2'b10, bus.in_funct[5:4], bus.in_imm24};
    end else begin
      enc_word_d = {bus.in_cond, bus.in_op, bus.in_funct, bus.in_rn, bus.in_rd, bus.in_src2};
    end

    word_d   = legal_d ? enc_word_d : NOP_WORD;
    accept_d = bus.in_valid & in_ready_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            err_q       <= 1'b0;
            err_count_q <= '0;
            if (num_instr_i != CNT_ZERO) begin
              addr_q      <= base_addr_i;
              remaining_q <= num_instr_i;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= S_LOAD;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end

        S_LOAD: begin
          if (accept_d) begin
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= word_d;
            if (!legal_d) begin
              err_q <= 1'b1;
              if (err_count_q != ERR_MAX) begin
                err_count_q <= err_count_q + ERR_ONE;
              end
            end
            state_q <= S_WRITE;
          end
        end

        S_WRITE: begin
          mem_we_q    <= 1'b0;
          addr_q      <= addr_q + ADDR_ONE;
          remaining_q <= remaining_q - CNT_ONE;
          if (remaining_q == CNT_ONE) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= S_LOAD;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign err_count_o   = err_count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed scenarios plus randomized sessions
// checked against an arithmetic model of the instruction encoding rules.
module tb_instr_encoder_loader;

  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
  } bundle_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] num_instr = '0;
  logic       busy, done, err;
  logic [7:0] err_count;

  int checks = 0;
  int failures = 0;
  wr_t obs_q[$];

  instr_encoder_loader_if #(.ADDR_W(8)) ifc ();

  instr_encoder_loader #(.ADDR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .base_addr_i (base_addr),
    .num_instr_i (num_instr),
    .bus         (ifc),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .err_count_o (err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifc.mem_we === 1'b1) begin
      wr_t w;
      w.addr = ifc.mem_addr;
      w.data = ifc.mem_wdata;
      obs_q.push_back(w);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference: {illegal, word} straight from the encoding table.
  function automatic logic [32:0] ref_encode(input bundle_t b);
    int unsigned w;
    int unsigned cmd;
    bit legal;
    cmd = (32'(b.funct) >> 1) & 32'hF;
    case (b.op)
      2'd0:    legal = (cmd inside {4, 2, 0, 12, 13, 1, 15});
      2'd1:    legal = 1'b1;
      2'd2:    legal = b.funct[5];
      default: legal = 1'b0;
    endcase
    if (!legal) w = 32'hE000_0000;
    else if (b.op == 2'd2)
      w = (32'(b.cond) << 28) | (32'd2 << 26) | ((32'(b.funct) >> 4) << 24) | 32'(b.imm24);
    else
      w = (32'(b.cond) << 28) | (32'(b.op) << 26) | (32'(b.funct) << 20) |
          (32'(b.rn) << 16) | (32'(b.rd) << 12) | 32'(b.src2);
    return {(legal ? 1'b0 : 1'b1), w[31:0]};
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    int legal_cmds[7] = '{4, 2, 0, 12, 13, 1, 15};
    b.cond  = 4'($urandom_range(0, 15));
    b.op    = 2'($urandom_range(0, 3));
    b.funct = 6'($urandom_range(0, 63));
    b.rn    = 4'($urandom_range(0, 15));
    b.rd    = 4'($urandom_range(0, 15));
    b.src2  = 12'($urandom_range(0, 4095));
    b.imm24 = 24'($urandom);
    if (b.op == 2'd0 && $urandom_range(0, 1) == 1)
      b.funct[4:1] = 4'(legal_cmds[$urandom_range(0, 6)]);
    return b;
  endfunction

  function automatic bundle_t mk(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                                 input logic [3:0] n, input logic [3:0] d,
                                 input logic [11:0] s, input logic [23:0] i);
    bundle_t b;
    b.cond = c; b.op = o; b.funct = f; b.rn = n; b.rd = d; b.src2 = s; b.imm24 = i;
    return b;
  endfunction

  task automatic drive_fields(input bundle_t b);
    ifc.in_cond  = b.cond;
    ifc.in_op    = b.op;
    ifc.in_funct = b.funct;
    ifc.in_rn    = b.rn;
    ifc.in_rd    = b.rd;
    ifc.in_src2  = b.src2;
    ifc.in_imm24 = b.imm24;
  endtask

  task automatic start_session(input logic [7:0] base, input logic [8:0] num);
    start = 1'b1;
    base_addr = base;
    num_instr = num;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents a bundle until accepted; returns on the negedge after the accepting edge.
  task automatic send_bundle(input bundle_t b, output bit ok);
    drive_fields(b);
    ifc.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (ifc.in_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    int cyc;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < budget) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    ifc.in_valid = 1'b0;
    drive_fields('0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ifc.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", ifc.in_ready); end
    checks++; if (ifc.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", ifc.mem_we); end
    checks++; if (ifc.mem_addr !== 8'h00) begin failures++; $display("FAIL reset_mem_addr got=%h exp=00", ifc.mem_addr); end
    checks++; if (ifc.mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", ifc.mem_wdata); end
    checks++; if ({busy, done, err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, err}); end
    checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: outputs checked after reset release");
  endtask

  task automatic test_single();
    bit ok;
    obs_q.delete();
    start_session(8'h10, 9'd1);
    checks++; if (ifc.in_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL single_start_latency got=ready%b/busy%b exp=1/1", ifc.in_ready, busy); end
    send_bundle(mk(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0), ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_accept got=timeout exp=accepted"); end
    checks++; if (ifc.mem_we !== 1'b1 || ifc.in_ready !== 1'b0) begin failures++; $display("FAIL single_write_cycle got=we%b/ready%b exp=1/0", ifc.mem_we, ifc.in_ready); end
    checks++; if (ifc.mem_addr !== 8'h10 || ifc.mem_wdata !== 32'hE282_1005) begin failures++; $display("FAIL single_word got=%h:%h exp=10:e2821005", ifc.mem_addr, ifc.mem_wdata); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || ifc.mem_we !== 1'b0) begin failures++; $display("FAIL single_done got=done%b/busy%b/we%b exp=1/0/0", done, busy, ifc.mem_we); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", err); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0", done); end
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL single_write_count got=%0d exp=1", obs_q.size()); end
    $display("single: addr=10 data=e2821005 session complete");
  endtask

  task automatic test_back_to_back();
    bundle_t b0, b1;
    logic [3:0] rdy;
    int acc;
    obs_q.delete();
    b0 = mk(4'hE, 2'b01, 6'b011001, 4'd4, 4'd3, 12'h008, 24'h0);
    b1 = mk(4'hE, 2'b10, 6'b10_0110, 4'd7, 4'd9, 12'hABC, 24'h000010);
    start_session(8'h00, 9'd2);
    drive_fields(b0);
    ifc.in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      rdy[i] = ifc.in_ready;
      if (ifc.in_ready === 1'b1) acc++;
      @(negedge clk);
      if (acc == 1) drive_fields(b1);
    end
    ifc.in_valid = 1'b0;
    checks++; if (rdy !== 4'b0101) begin failures++; $display("FAIL b2b_ready_pattern got=%b exp=0101", rdy); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", done); end
    @(negedge clk);
    checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL b2b_write_count got=%0d exp=2", obs_q.size()); end
    else begin
      checks++; if (obs_q[0].addr !== 8'h00 || obs_q[0].data !== 32'hE594_3008) begin failures++; $display("FAIL b2b_ldr got=%h:%h exp=00:e5943008", obs_q[0].addr, obs_q[0].data); end
      checks++; if (obs_q[1].addr !== 8'h01 || obs_q[1].data !== 32'hEA00_0010) begin failures++; $display("FAIL b2b_branch got=%h:%h exp=01:ea000010", obs_q[1].addr, obs_q[1].data); end
    end
    $display("back_to_back: ready pattern %b, %0d writes", rdy, obs_q.size());
  endtask

  task automatic test_illegal();
    bundle_t bq[3];
    bit ok, seen;
    logic [31:0] exp_data[3] = '{32'hE000_0000, 32'hE000_0000, 32'hE085_6007};
    obs_q.delete();
    bq[0] = mk(4'h3, 2'b11, 6'b111111, 4'd1, 4'd2, 12'h123, 24'h456789);
    bq[1] = mk(4'hE, 2'b00, 6'b010100, 4'd1, 4'd2, 12'h003, 24'h0);
    bq[2] = mk(4'hE, 2'b00, 6'b001000, 4'd5, 4'd6, 12'h007, 24'h0);
    start_session(8'h40, 9'd3);
    for (int i = 0; i < 3; i++) begin
      send_bundle(bq[i], ok);
      checks++; if (!ok) begin failures++; $display("FAIL illegal_accept%0d got=timeout exp=accepted", i); end
    end
    wait_done(20, seen);
    checks++; if (!seen) begin failures++; $display("FAIL illegal_done got=timeout exp=done"); end
    @(negedge clk);
    checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL illegal_write_count got=%0d exp=3", obs_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (obs_q[i].addr !== 8'(8'h40 + i) || obs_q[i].data !== exp_data[i]) begin failures++; $display("FAIL illegal_word%0d got=%h:%h exp=%h:%h", i, obs_q[i].addr, obs_q[i].data, 8'(8'h40 + i), exp_data[i]); end
    end
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b1 || err_count !== 8'd2) begin failures++; $display("FAIL illegal_err_hold got=%b/%0d exp=1/2", err, err_count); end
    $display("illegal: err=%b err_count=%0d", err, err_count);
  endtask

  task automatic test_wrap_start_ignored();
    bundle_t b0, b1;
    logic [32:0] r0, r1;
    bit ok, seen;
    obs_q.delete();
    b0 = mk(4'h1, 2'b01, 6'b000000, 4'd8, 4'd9, 12'hFFF, 24'h0);
    b1 = mk(4'hA, 2'b00, 6'b011010, 4'd3, 4'd4, 12'h0F0, 24'h0);
    r0 = ref_encode(b0);
    r1 = ref_encode(b1);
    start_session(8'hFF, 9'd2);
    send_bundle(b0, ok);
    start_session(8'h40, 9'd5);
    start = 1'b1;
    send_bundle(b1, ok);
    start = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL wrap_accept got=timeout exp=accepted"); end
    wait_done(20, seen);
    checks++; if (!seen) begin failures++; $display("FAIL wrap_done got=timeout exp=done"); end
    repeat (5) @(negedge clk);
    checks++; if (obs_q.size() != 2 || busy !== 1'b0) begin failures++; $display("FAIL wrap_session_len got=%0d/busy%b exp=2/0", obs_q.size(), busy); end
    else begin
      checks++; if (obs_q[0].addr !== 8'hFF || obs_q[0].data !== r0[31:0]) begin failures++; $display("FAIL wrap_first got=%h:%h exp=ff:%h", obs_q[0].addr, obs_q[0].data, r0[31:0]); end
      checks++; if (obs_q[1].addr !== 8'h00 || obs_q[1].data !== r1[31:0]) begin failures++; $display("FAIL wrap_second got=%h:%h exp=00:%h", obs_q[1].addr, obs_q[1].data, r1[31:0]); end
    end
    $display("wrap: writes at ff then 00, mid-session start ignored");
  endtask

  task automatic test_saturate();
    bit ok, seen;
    int bad;
    bundle_t b;
    obs_q.delete();
    bad = 0;
    start_session(8'h80, 9'd260);
    for (int i = 0; i < 260; i++) begin
      b = rand_bundle();
      b.op = 2'b11;
      send_bundle(b, ok);
      if (!ok) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL sat_accept got=%0d stalls exp=0", bad); end
    wait_done(20, seen);
    checks++; if (!seen) begin failures++; $display("FAIL sat_done got=timeout exp=done"); end
    @(negedge clk);
    bad = 0;
    foreach (obs_q[i]) if (obs_q[i].data !== 32'hE000_0000 || obs_q[i].addr !== 8'(8'h80 + i)) bad++;
    checks++; if (obs_q.size() != 260 || bad != 0) begin failures++; $display("FAIL sat_writes got=%0d writes/%0d wrong exp=260/0", obs_q.size(), bad); end
    checks++; if (err !== 1'b1 || err_count !== 8'd255) begin failures++; $display("FAIL sat_err_count got=%b/%0d exp=1/255", err, err_count); end
    $display("saturate: 260 illegal bundles, err_count=%0d", err_count);
  endtask

  task automatic test_zero();
    obs_q.delete();
    start_session(8'h55, 9'd0);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL zero_done got=done%b/busy%b exp=1/0", done, busy); end
    checks++; if (err !== 1'b0 || err_count !== 8'd0) begin failures++; $display("FAIL zero_err_clear got=%b/%0d exp=0/0", err, err_count); end
    repeat (3) @(negedge clk);
    checks++; if (obs_q.size() != 0 || done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zero_no_write got=%0d/done%b/busy%b exp=0/0/0", obs_q.size(), done, busy); end
    $display("zero: done with no writes");
  endtask

  task automatic test_reset_mid();
    bundle_t b;
    logic [32:0] r;
    bit ok, seen;
    obs_q.delete();
    start_session(8'h20, 9'd1);
    drive_fields(mk(4'hE, 2'b01, 6'b011001, 4'd1, 4'd2, 12'h004, 24'h0));
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    checks++; if ({ifc.in_ready, ifc.mem_we, busy, done, err} !== 5'b0) begin failures++; $display("FAIL rstmid_flags got=%b exp=00000", {ifc.in_ready, ifc.mem_we, busy, done, err}); end
    checks++; if (ifc.mem_addr !== 8'h0 || ifc.mem_wdata !== 32'h0 || err_count !== 8'h0) begin failures++; $display("FAIL rstmid_values got=%h:%h/%0d exp=00:0/0", ifc.mem_addr, ifc.mem_wdata, err_count); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rstmid_no_write got=%0d exp=0", obs_q.size()); end
    b = rand_bundle();
    r = ref_encode(b);
    start_session(8'h30, 9'd1);
    send_bundle(b, ok);
    wait_done(20, seen);
    @(negedge clk);
    checks++; if (!ok || !seen || obs_q.size() != 1) begin failures++; $display("FAIL rstmid_recover got=ok%b/done%b/%0d exp=1/1/1", ok, seen, obs_q.size()); end
    else begin
      checks++; if (obs_q[0].addr !== 8'h30 || obs_q[0].data !== r[31:0]) begin failures++; $display("FAIL rstmid_word got=%h:%h exp=30:%h", obs_q[0].addr, obs_q[0].data, r[31:0]); end
    end
    $display("reset_mid: pending word discarded, next session ok");
  endtask

  task automatic test_random();
    bundle_t bq[$];
    logic [32:0] r;
    logic [7:0] base;
    int n, nill, exp_cnt;
    bit ok, seen;
    for (int s = 0; s < 8; s++) begin
      obs_q.delete();
      bq.delete();
      base = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 7);
      nill = 0;
      for (int i = 0; i < n; i++) bq.push_back(rand_bundle());
      start_session(base, 9'(n));
      foreach (bq[i]) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_bundle(bq[i], ok);
      end
      wait_done(30, seen);
      @(negedge clk);
      checks++; if (!seen || obs_q.size() != n) begin failures++; $display("FAIL rand%0d_len got=done%b/%0d exp=1/%0d", s, seen, obs_q.size(), n); end
      else foreach (bq[i]) begin
        r = ref_encode(bq[i]);
        if (r[32]) nill++;
        checks++; if (obs_q[i].addr !== 8'(base + i) || obs_q[i].data !== r[31:0]) begin failures++; $display("FAIL rand%0d_word%0d got=%h:%h exp=%h:%h", s, i, obs_q[i].addr, obs_q[i].data, 8'(base + i), r[31:0]); end
      end
      exp_cnt = (nill > 255) ? 255 : nill;
      checks++; if (err_count !== 8'(exp_cnt) || err !== (nill > 0)) begin failures++; $display("FAIL rand%0d_err got=%b/%0d exp=%b/%0d", s, err, err_count, (nill > 0), exp_cnt); end
      $display("random session %0d: base=%h n=%0d illegal=%0d", s, base, n, nill);
    end
  endtask

  initial begin
    ifc.in_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal();
    test_wrap_start_ignored();
    test_saturate();
    test_zero();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
